// File: rtl/mult_pkg.sv
// Shared types and default widths for the shift-add signed multiply sequencer.
package mult_pkg;

    localparam int MULT_W = 8;
    localparam int PROD_W = 2*MULT_W-1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rise_detect.sv
// One-cycle rising-edge detector whose first post-reset cycle only primes the
// history register, so an input already high at reset release never fires.
module rise_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_level,
    output logic o_go
);

    logic r_start_q;
    logic r_armed;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_start_q <= 1'b0;
            r_armed   <= 1'b0;
        end else begin
            r_start_q <= i_level;
            r_armed   <= 1'b1;
        end
    end

    assign o_go = r_armed & i_level & ~r_start_q;

endmodule

// File: rtl/mult_sequencer.sv
// Sequences a W-iteration shift-add multiply of two signed operands, producing
// an unsigned magnitude product plus a separate sign bit.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int W = MULT_W
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  signal_in,
    input  logic signed [W-1:0]   multiplicand,
    input  logic signed [W-1:0]   multiplier,
    output logic                  load,
    output logic                  busy,
    output logic                  done,
    output logic                  led,
    output logic        [2*W-2:0] product,
    output logic                  sign
);

    localparam int P_W   = 2*W-1;
    localparam int CNT_W = $clog2(W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W-1);

    // Negation of the most-negative value wraps to 2^(W-1), which is the
    // correct magnitude once the result is read as unsigned.
    function automatic logic [W-1:0] magnitude(input logic signed [W-1:0] x);
        logic [W-1:0] neg;
        neg = W'(-x);
        return x[W-1] ? neg : W'(x);
    endfunction

    state_t             r_state;
    logic [P_W-1:0]     r_mcand;
    logic [W-1:0]       r_mplier;
    logic [P_W-1:0]     r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_sign;
    logic               r_led;
    logic [P_W-1:0]     r_product;
    logic               r_sign_out;

    logic               w_go;
    logic [P_W-1:0]     w_acc_next;

    rise_detect u_rise_detect (
        .i_clk   (sys_clk),
        .i_rst   (rst),
        .i_level (signal_in),
        .o_go    (w_go)
    );

    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_sign     <= 1'b0;
            r_led      <= 1'b0;
            r_product  <= '0;
            r_sign_out <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_go) r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    r_mcand  <= {{(W-1){1'b0}}, magnitude(multiplicand)};
                    r_mplier <= magnitude(multiplier);
                    r_acc    <= '0;
                    r_cnt    <= '0;
                    r_sign   <= multiplicand[W-1] ^ multiplier[W-1];
                    r_led    <= 1'b0;
                    r_state  <= ST_RUN;
                end
                ST_RUN: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_LAST) begin
                        r_product  <= w_acc_next;
                        // A zero product is always reported positive.
                        r_sign_out <= (w_acc_next == '0) ? 1'b0 : r_sign;
                        r_state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_led   <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign load    = (r_state == ST_LOAD);
    assign busy    = (r_state == ST_LOAD) || (r_state == ST_RUN);
    assign done    = (r_state == ST_DONE);
    assign led     = r_led;
    assign product = r_product;
    assign sign    = r_sign_out;

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed and randomized bench for mult_sequencer against an arithmetic model.
module tb_mult_sequencer;

    localparam int W = 8;

    logic                  sys_clk;
    logic                  rst;
    logic                  signal_in;
    logic signed [W-1:0]   multiplicand;
    logic signed [W-1:0]   multiplier;
    logic                  load;
    logic                  busy;
    logic                  done;
    logic                  led;
    logic        [2*W-2:0] product;
    logic                  sign;

    int checks = 0;
    int errors = 0;
    int n_done = 0;
    int n_load = 0;
    int prev_p = 0;
    int prev_s = 0;

    mult_sequencer #(.W(W)) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .signal_in    (signal_in),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .load         (load),
        .busy         (busy),
        .done         (done),
        .led          (led),
        .product      (product),
        .sign         (sign)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) begin
        if (done) n_done <= n_done + 1;
        if (load) n_load <= n_load + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                                  output int p, output int s);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        p = (ia < 0 ? -ia : ia) * (ib < 0 ? -ib : ib);
        s = (p != 0 && ((ia < 0) != (ib < 0))) ? 1 : 0;
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic run_txn(input logic signed [W-1:0] a, input logic signed [W-1:0] b);
        int ep;
        int es;
        model(a, b, ep, es);
        multiplicand = a;
        multiplier   = b;
        signal_in    = 1'b1;
        tick();
        check("load_pulse", 64'(load), 64'd1);
        check("busy_load", 64'(busy), 64'd1);
        signal_in = 1'b0;
        for (int i = 0; i < W; i++) begin
            tick();
            check("busy_run", 64'(busy), 64'd1);
            check("done_run", 64'(done), 64'd0);
            check("led_run", 64'(led), 64'd0);
            check("hold_product", 64'(product), 64'(prev_p));
            check("hold_sign", 64'(sign), 64'(prev_s));
            if (i == 2) begin
                multiplicand = W'($urandom);
                multiplier   = W'($urandom);
            end
        end
        tick();
        check("done_pulse", 64'(done), 64'd1);
        check("busy_done", 64'(busy), 64'd0);
        check("product", 64'(product), 64'(ep));
        check("sign", 64'(sign), 64'(es));
        tick();
        check("done_clear", 64'(done), 64'd0);
        check("led_set", 64'(led), 64'd1);
        prev_p = ep;
        prev_s = es;
    endtask

    initial begin
        int ep;
        int es;
        int d0;
        int l0;
        logic signed [W-1:0] ra;
        logic signed [W-1:0] rb;

        rst          = 1'b1;
        signal_in    = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        repeat (2) tick();
        check("rst_product", 64'(product), 64'd0);
        check("rst_sign", 64'(sign), 64'd0);
        check("rst_load", 64'(load), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_led", 64'(led), 64'd0);
        rst = 1'b0;
        repeat (2) tick();

        run_txn(8'sd14, 8'sd13);
        repeat (3) tick();
        check("led_held", 64'(led), 64'd1);
        run_txn(-8'sd5, 8'sd7);
        run_txn(-8'sd128, -8'sd128);
        run_txn(8'sd0, -8'sd9);
        run_txn(8'sd127, -8'sd128);
        run_txn(-8'sd1, 8'sd1);

        for (int k = 0; k < 20; k++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_txn(ra, rb);
            repeat ($urandom_range(0, 2)) tick();
        end

        // Retrigger mid-RUN with operands changed: one result, original operands.
        model(8'sd23, -8'sd6, ep, es);
        d0 = n_done;
        l0 = n_load;
        multiplicand = 8'sd23;
        multiplier   = -8'sd6;
        signal_in    = 1'b1;
        tick();
        signal_in = 1'b0;
        repeat (3) tick();
        signal_in    = 1'b1;
        multiplicand = -8'sd77;
        multiplier   = 8'sd99;
        tick();
        signal_in = 1'b0;
        repeat (12) tick();
        check("retrig_done_cnt", 64'(n_done - d0), 64'd1);
        check("retrig_load_cnt", 64'(n_load - l0), 64'd1);
        check("retrig_product", 64'(product), 64'(ep));
        check("retrig_sign", 64'(sign), 64'(es));

        // Held start high for 30 cycles.
        model(-8'sd100, -8'sd3, ep, es);
        d0 = n_done;
        l0 = n_load;
        multiplicand = -8'sd100;
        multiplier   = -8'sd3;
        signal_in    = 1'b1;
        repeat (30) tick();
        signal_in = 1'b0;
        repeat (5) tick();
        check("held_done_cnt", 64'(n_done - d0), 64'd1);
        check("held_load_cnt", 64'(n_load - l0), 64'd1);
        check("held_product", 64'(product), 64'(ep));
        check("held_sign", 64'(sign), 64'(es));

        // Reset during RUN cycle 4.
        multiplicand = 8'sd100;
        multiplier   = 8'sd3;
        signal_in    = 1'b1;
        tick();
        signal_in = 1'b0;
        repeat (4) tick();
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_product", 64'(product), 64'd0);
        check("midrst_sign", 64'(sign), 64'd0);
        check("midrst_load", 64'(load), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_led", 64'(led), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        d0 = n_done;
        repeat (15) tick();
        check("postrst_done_cnt", 64'(n_done - d0), 64'd0);
        check("postrst_busy", 64'(busy), 64'd0);
        check("postrst_product", 64'(product), 64'd0);
        prev_p = 0;
        prev_s = 0;

        // signal_in already high when reset releases.
        signal_in = 1'b1;
        rst       = 1'b1;
        repeat (2) tick();
        #4;
        rst = 1'b0;
        l0 = n_load;
        d0 = n_done;
        repeat (15) tick();
        check("hi_rst_load_cnt", 64'(n_load - l0), 64'd0);
        check("hi_rst_done_cnt", 64'(n_done - d0), 64'd0);
        check("hi_rst_busy", 64'(busy), 64'd0);
        signal_in = 1'b0;
        repeat (2) tick();
        run_txn(-8'sd128, 8'sd127);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
